byte_frame_tx: RTL and testbench
================================

# byte_frame_tx

Downstream framing stage for the 56-bit byte-shift capture register. It accepts one 56-bit word per valid/ready handshake and emits it as a byte stream: a fixed header byte, the 7 data bytes with the most-recently-captured byte last, and an optional XOR checksum byte. Output uses a valid/ready handshake with backpressure, which makes it suitable for feeding a UART/SPI transmitter or the bidirectional IO bus. A frame counter and a synchronous flush support bring-up and debug.

## Interface
- HEADER, 8'hA5, value of the first byte of every frame
- CSUM_EN, 1, 1 = append XOR checksum byte (9-byte frame); 0 = omit it (8-byte frame)
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset; one clock; reset is asynchronous and active-high
- flush  input  1  synchronous abort of the frame in progress
- in_valid  input  1  in_data holds a word to send
- in_data  input  56  word; byte k = in_data[8k+7:8k]
- in_ready  output  1  block can accept a word this cycle
- out_valid  output  1  out_data holds a byte
- out_data  output  8  current frame byte
- out_last  output  1  current byte is the final byte of the frame
- out_ready  input  1  downstream accepts out_data this cycle
- busy  output  1  a frame is in progress (state != IDLE)
- frame_count  output  8  number of completed frames, wraps

## Operation
- States: IDLE, HDR, DATA, CSUM.
- IDLE: in_ready=1 (forced 0 while flush=1). On in_valid&in_ready: latch in_data into a 56-bit holding register, clear the checksum accumulator, set byte index to 6, go to HDR.
- HDR: out_data=HEADER. On out_valid&out_ready go to DATA.
- DATA: out_data = hold[8·idx+7 : 8·idx]. Bytes go out in the order idx 6,5,…,0 (hold[55:48] first, hold[7:0] last). On each accepted byte: csum ^= out_data and idx decrements. After idx 0 is accepted, go to CSUM if CSUM_EN=1, otherwise go to IDLE.
- CSUM: out_data = XOR of the 7 data bytes. On acceptance go to IDLE.
- out_valid=1 in HDR, DATA, and CSUM. out_last=1 in CSUM, or on DATA idx 0 when CSUM_EN=0.
- frame_count increments by 1 (mod 256) on acceptance of the out_last byte.
- flush=1: next state is IDLE from any state and the partial frame is discarded. frame_count is unchanged, even if the out_last byte is handshaked in the same cycle. flush takes priority over both input and output handshakes.
- The holding register changes only on input acceptance. in_data may change freely after acceptance.

## Timing
- Reset (async assert; release is synchronous to clk): state=IDLE, in_ready=1, out_valid=0, out_data=8'h00, out_last=0, busy=0, frame_count=0, hold=0, csum=0.
- A word accepted at edge N gives out_valid=1 with HEADER after edge N, i.e. 1 cycle of latency.
- Each byte stays on out_data, with out_valid held high and out_data/out_last stable, until out_ready=1. No byte is skipped or repeated.
- With out_ready held at 1, a frame occupies 9 cycles (8 when CSUM_EN=0). It returns to IDLE after the last byte is accepted, and in_ready=1 in the following cycle. Minimum input period is 10 cycles (9 when CSUM_EN=0).
- out_valid is 0 in IDLE, and out_data is 8'h00 in IDLE.
- Reset asserted mid-frame: outputs return to their reset values immediately (asynchronously) and the frame is lost.

## Test plan
- Basic frame: rst pulse; in_data=56'hDEADBEEF012345 with in_valid for 1 cycle; out_ready=1. Required stream: A5,DE,AD,BE,EF,01,23,45,45 on consecutive cycles; out_last only on the 9th byte; frame_count=1; in_ready=1 one cycle later.
- Backpressure: same word; toggle out_ready pseudo-randomly. Required: identical 9-byte sequence; out_data and out_last stable while out_valid&!out_ready; in_ready=0 throughout the frame.
- CSUM_EN=0, HEADER=8'h3C: in_data=56'h11223344556677. Required stream: 3C,11,22,33,44,55,66,77 with out_last on 77; then an idle cycle.
- Back-to-back: in_valid held high with two words, 56'h01020304050607 then 56'h0. Required: the second word is accepted only in IDLE after the first frame; checksums 0x00 and 0x00; frame_count=2.
- Flush: assert flush in the cycle the 4th data byte is presented. Required: IDLE next cycle, out_valid=0, frame_count unchanged, in_ready=0 during the flush cycle. The next frame is complete and correct.
- Reset mid-frame and wrap: assert rst during DATA. Required: all outputs reach reset values before the next edge. Separately, send 256 frames. Required: frame_count goes 255→0.

Source files
------------

// File: rtl/byte_frame_tx_if.sv
// Stream bundle for byte_frame_tx: 56-bit word input handshake and
// byte output handshake with a frame-end marker.
interface byte_frame_tx_if;
    logic        in_valid;
    logic [55:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_ready;

    // Framer side
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_last
    );

    // Producer / consumer side
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_last
    );
endinterface

// File: rtl/byte_frame_tx.sv
// Frames a 56-bit word as: header byte, 7 data bytes (MSB byte first),
// optional XOR checksum byte. Valid/ready on both sides, with a
// synchronous flush and a wrapping completed-frame counter.
module byte_frame_tx #(
    parameter logic [7:0] HEADER  = 8'hA5,
    parameter bit         CSUM_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    byte_frame_tx_if.slave  bus,
    output logic            busy,
    output logic [7:0]      frame_count
);

    typedef enum logic [1:0] {IDLE, HDR, DATA, CSUM} state_t;

    state_t      state_q, state_d;
    logic [55:0] hold_q;
    logic [7:0]  csum_q;
    logic [2:0]  idx_q;
    logic        in_fire;
    logic        out_fire;

    // flush suppresses both handshakes; in_ready already carries !flush
    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = bus.out_valid && bus.out_ready && !flush;
    assign busy     = (state_q != IDLE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and output decode; outputs depend only on state so an
    // asynchronous reset drives them to idle values immediately
    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.out_last  = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = !flush;
                if (bus.in_valid && !flush) state_d = HDR;
            end
            HDR: begin
                bus.out_valid = 1'b1;
                bus.out_data  = HEADER;
                if (bus.out_ready) state_d = DATA;
            end
            DATA: begin
                bus.out_valid = 1'b1;
                bus.out_data  = hold_q[{idx_q, 3'b000} +: 8];
                bus.out_last  = !CSUM_EN && (idx_q == 3'd0);
                if (bus.out_ready && (idx_q == 3'd0))
                    state_d = CSUM_EN ? CSUM : IDLE;
            end
            CSUM: begin
                bus.out_valid = 1'b1;
                bus.out_data  = csum_q;
                bus.out_last  = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // Holding register, byte index, checksum accumulator and frame counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q      <= '0;
            csum_q      <= '0;
            idx_q       <= '0;
            frame_count <= '0;
        end else begin
            if (in_fire) begin
                hold_q <= bus.in_data;
                csum_q <= '0;
                idx_q  <= 3'd6;
            end else if (out_fire && (state_q == DATA)) begin
                csum_q <= csum_q ^ bus.out_data;
                idx_q  <= idx_q - 3'd1;
            end
            if (out_fire && bus.out_last)
                frame_count <= frame_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_byte_frame_tx.sv
// Directed bench for byte_frame_tx: one DUT with default parameters and
// one with CSUM_EN=0 / HEADER=8'h3C, sharing clock, reset, flush and out_ready.
module tb_byte_frame_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        rdy = 1'b1;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [55:0] a_data = '0, b_data = '0;
    logic        sel = 1'b0;
    logic        a_busy, b_busy;
    logic [7:0]  a_fc, b_fc;

    logic        o_valid, o_last, o_in_ready, o_busy;
    logic [7:0]  o_data, o_fc;

    int unsigned total = 0;
    int unsigned bad = 0;

    byte_frame_tx_if aif ();
    byte_frame_tx_if bif ();

    assign aif.in_valid  = a_valid;
    assign aif.in_data   = a_data;
    assign aif.out_ready = rdy;
    assign bif.in_valid  = b_valid;
    assign bif.in_data   = b_data;
    assign bif.out_ready = rdy;

    assign o_valid    = sel ? bif.out_valid : aif.out_valid;
    assign o_last     = sel ? bif.out_last  : aif.out_last;
    assign o_data     = sel ? bif.out_data  : aif.out_data;
    assign o_in_ready = sel ? bif.in_ready  : aif.in_ready;
    assign o_busy     = sel ? b_busy : a_busy;
    assign o_fc       = sel ? b_fc   : a_fc;

    byte_frame_tx u_dut_a (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .bus         (aif),
        .busy        (a_busy),
        .frame_count (a_fc)
    );

    byte_frame_tx #(.HEADER(8'h3C), .CSUM_EN(1'b0)) u_dut_b (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .bus         (bif),
        .busy        (b_busy),
        .frame_count (b_fc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a word at the next falling edge; accepted on the following rise
    task automatic send(input bit to_b, input logic [55:0] d);
        @(negedge clk);
        sel = to_b;
        if (to_b) begin b_valid = 1'b1; b_data = d; end
        else      begin a_valid = 1'b1; a_data = d; end
        chk("in_ready_idle", o_in_ready, 1);
    endtask

    // Follow one frame; bytes left-aligned in a 72-bit vector, first byte in MSBs
    task automatic expect_frame(input logic [71:0] bytes, input int unsigned n,
                                input bit bp, input bit drop_valid);
        int unsigned i;
        bit r;
        i = 0;
        for (int unsigned c = 0; c < 400 && i < n; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk("first_latency", o_valid, 1);
                if (drop_valid) begin a_valid = 1'b0; b_valid = 1'b0; end
            end else begin
                chk("valid_held", o_valid, 1);
            end
            chk("byte", o_data, bytes[(71 - 8*i) -: 8]);
            chk("last", o_last, (i == n - 1));
            chk("in_ready_busy", o_in_ready, 0);
            r = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            rdy = r;
            if (r) i++;
        end
        if (i < n) chk("frame_timeout", i, n);
    endtask

    initial begin
        int unsigned prev;
        bit wrapped;

        // Reset state
        #2;
        chk("rst_in_ready", aif.in_ready, 1);
        chk("rst_out_valid", aif.out_valid, 0);
        chk("rst_out_data", aif.out_data, 8'h00);
        chk("rst_out_last", aif.out_last, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_fc", a_fc, 0);
        chk("rst_b_fc", b_fc, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Basic frame
        send(1'b0, 56'hDEADBEEF012345);
        expect_frame(72'hA5_DEADBEEF012345_45, 9, 1'b0, 1'b1);
        @(negedge clk);
        chk("basic_idle_valid", o_valid, 0);
        chk("basic_idle_data", o_data, 8'h00);
        chk("basic_in_ready", o_in_ready, 1);
        chk("basic_fc", o_fc, 1);
        chk("basic_busy", o_busy, 0);

        // Backpressure
        send(1'b0, 56'hDEADBEEF012345);
        expect_frame(72'hA5_DEADBEEF012345_45, 9, 1'b1, 1'b1);
        rdy = 1'b1;
        @(negedge clk);
        chk("bp_fc", o_fc, 2);
        chk("bp_in_ready", o_in_ready, 1);

        // No checksum, alternate header
        send(1'b1, 56'h11223344556677);
        expect_frame(72'h3C_11223344556677_00, 8, 1'b0, 1'b1);
        @(negedge clk);
        chk("nocs_idle_valid", o_valid, 0);
        chk("nocs_idle_last", o_last, 0);
        chk("nocs_fc", o_fc, 1);
        chk("nocs_in_ready", o_in_ready, 1);
        sel = 1'b0;

        // Back-to-back with in_valid held, from a fresh reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send(1'b0, 56'h01020304050607);
        @(posedge clk);
        #1 a_data = 56'h0;
        expect_frame(72'hA5_01020304050607_00, 9, 1'b0, 1'b0);
        @(negedge clk);
        chk("b2b_gap_valid", o_valid, 0);
        chk("b2b_gap_in_ready", o_in_ready, 1);
        chk("b2b_gap_fc", o_fc, 1);
        expect_frame(72'hA5_00000000000000_00, 9, 1'b0, 1'b1);
        @(negedge clk);
        chk("b2b_fc", o_fc, 2);

        // Flush on the 4th data byte
        send(1'b0, 56'hDEADBEEF012345);
        @(negedge clk);
        a_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("flush_pre_byte", o_data, 8'hEF);
        flush = 1'b1;
        chk("flush_in_ready", o_in_ready, 0);
        @(negedge clk);
        chk("flush_valid", o_valid, 0);
        chk("flush_busy", o_busy, 0);
        chk("flush_fc", o_fc, 2);
        chk("flush_idle_in_ready", o_in_ready, 0);
        a_valid = 1'b1;
        a_data  = 56'h0;
        @(negedge clk);
        chk("flush_blocks_accept", o_busy, 0);
        flush   = 1'b0;
        a_valid = 1'b0;
        send(1'b0, 56'hDEADBEEF012345);
        expect_frame(72'hA5_DEADBEEF012345_45, 9, 1'b0, 1'b1);
        @(negedge clk);
        chk("post_flush_fc", o_fc, 3);

        // Flush coinciding with the out_last handshake
        send(1'b0, 56'hDEADBEEF012345);
        @(negedge clk);
        a_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("flush_last_data", o_data, 8'h45);
        chk("flush_last_last", o_last, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_last_fc", o_fc, 3);
        chk("flush_last_valid", o_valid, 0);

        // Reset mid-frame: outputs must return before the next edge
        send(1'b0, 56'hDEADBEEF012345);
        @(negedge clk);
        a_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_data", o_data, 8'h00);
        chk("mid_rst_last", o_last, 0);
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_in_ready", o_in_ready, 1);
        chk("mid_rst_fc", o_fc, 0);
        @(negedge clk);
        rst = 1'b0;

        // 256 frames: frame_count steps by one and wraps 255 -> 0
        rdy     = 1'b1;
        a_valid = 1'b1;
        a_data  = 56'h0123456789ABCD;
        prev    = 0;
        wrapped = 1'b0;
        for (int unsigned c = 0; c < 4000 && !wrapped; c++) begin
            @(negedge clk);
            if (o_fc != prev[7:0]) begin
                chk("fc_step", o_fc, (prev + 1) % 256);
                if (prev == 255) wrapped = 1'b1;
                prev = o_fc;
            end
        end
        chk("wrap_seen", wrapped, 1);
        a_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
